// File: rtl/avr_pkg.sv
`default_nettype none
// ============================================================================
// avr_pkg : types and constants shared by the AVR serial link blocks
// Rev 1.0
// ============================================================================
package avr_pkg;

    localparam int c_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avr_uart_tx_if.sv
`default_nettype none
// ============================================================================
// avr_uart_tx_if : byte write port between fabric logic and avr_uart_tx
// Rev 1.0
// ============================================================================
interface avr_uart_tx_if;
    import avr_pkg::*;

    logic [c_DATA_WIDTH-1:0] data;
    logic                    new_data;
    logic                    full;
    logic                    busy;

    modport master (output data, output new_data, input full, input busy);
    modport slave  (input data, input new_data, output full, output busy);

endinterface
`default_nettype wire

// File: rtl/avr_uart_tx_byte_fifo.sv
`default_nettype none
// ============================================================================
// byte_fifo : synchronous FIFO with flush; head word is visible on rd_data
// Rev 1.0
// ============================================================================
module byte_fifo
    import avr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = c_DATA_WIDTH
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   wr,
    input  wire logic [WIDTH-1:0]       wr_data,
    input  wire logic                   rd,
    output logic      [WIDTH-1:0]       rd_data,
    input  wire logic                   flush,
    output logic      [$clog2(DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full    = (r_count == c_CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_push  = wr & ~full;
    assign w_pop   = rd & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/avr_uart_tx.sv
`default_nettype none
// ============================================================================
// avr_uart_tx : buffered 8N1 transmitter to the AVR with receive-busy pacing
// Rev 1.0
// ============================================================================
module avr_uart_tx
    import avr_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 500000,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     ready,
    input  wire logic     avr_busy,
    avr_uart_tx_if.slave  bus,
    output logic          tx
);

    localparam int                  c_CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int                  c_BAUD_W       = $clog2(c_CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST    = c_BAUD_W'(c_CLKS_PER_BIT - 1);
    localparam int                  c_CNT_W        = $clog2(FIFO_DEPTH) + 1;

    tx_state_e                 r_state, w_state_next;
    logic [c_BAUD_W-1:0]       r_baud, w_baud_next;
    logic [2:0]                r_bit, w_bit_next;
    logic [c_DATA_WIDTH-1:0]   r_shift, w_shift_next;
    logic                      r_tx, w_tx_next;
    logic                      r_busy_meta, r_busy_s;
    logic                      w_push, w_pop, w_start_ok, w_bit_end;
    logic [c_DATA_WIDTH-1:0]   w_fifo_rd_data;
    logic [c_CNT_W-1:0]        w_fifo_count;
    logic                      w_fifo_full, w_fifo_empty;

    assign bus.full   = w_fifo_full | ~ready;
    assign bus.busy   = (r_state != IDLE) | (w_fifo_count != '0);
    assign w_push     = bus.new_data & ~bus.full;
    assign w_start_ok = ready & ~r_busy_s & ~w_fifo_empty;
    assign w_bit_end  = (r_baud == c_BAUD_LAST);
    assign tx         = r_tx;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (w_push),
        .wr_data (bus.data),
        .rd      (w_pop),
        .rd_data (w_fifo_rd_data),
        .flush   (~ready),
        .count   (w_fifo_count),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // Reset to 1 so a frame cannot start before the AVR line has been seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_meta <= 1'b1;
            r_busy_s    <= 1'b1;
        end else begin
            r_busy_meta <= avr_busy;
            r_busy_s    <= r_busy_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;

        if (!ready) begin
            w_state_next = IDLE;
            w_baud_next  = '0;
            w_bit_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_rd_data;
                        w_baud_next  = '0;
                        w_state_next = START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        w_baud_next  = '0;
                        w_bit_next   = '0;
                        w_state_next = DATA;
                    end else begin
                        w_baud_next = r_baud + c_BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        w_baud_next  = '0;
                        w_shift_next = {1'b0, r_shift[c_DATA_WIDTH-1:1]};
                        if (r_bit == 3'd7) begin
                            w_state_next = STOP;
                        end else begin
                            w_bit_next = r_bit + 3'd1;
                        end
                    end else begin
                        w_baud_next = r_baud + c_BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        w_baud_next = '0;
                        if (w_start_ok) begin
                            w_pop        = 1'b1;
                            w_shift_next = w_fifo_rd_data;
                            w_state_next = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_baud_next = r_baud + c_BAUD_W'(1);
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Line level is registered from the next state so tx never glitches.
    always_comb begin
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_avr_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_avr_uart_tx : directed self-checking bench for avr_uart_tx (4 clks/bit)
// Rev 1.0
// ============================================================================
module tb_avr_uart_tx;

    logic clk = 1'b0;
    logic rst;
    logic ready;
    logic avr_busy;
    logic tx;
    int   n_tests = 0;
    int   n_fail  = 0;

    avr_uart_tx_if bus ();

    avr_uart_tx #(
        .CLK_FREQ   (2000000),
        .BAUD       (500000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .avr_busy (avr_busy),
        .bus      (bus.slave),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the negedge just after the START edge; returns at the negedge
    // after the edge that ends the stop bit.
    task automatic frame_check(input logic [7:0] b, input int busy_at);
        logic exp;
        for (int i = 0; i < 40; i++) begin
            if (i == busy_at) avr_busy = 1'b1;
            if (i < 4)       exp = 1'b0;
            else if (i < 36) exp = b[(i - 4) / 4];
            else             exp = 1'b1;
            check_eq($sformatf("frame %02h cyc %0d", b, i), tx, exp);
            if (i == 0 || i == 39) check_eq($sformatf("frame %02h busy %0d", b, i), bus.busy, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.data     = d;
        bus.new_data = 1'b1;
        @(negedge clk);
        bus.new_data = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s tx %0d", tag, i), tx, 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        ready        = 1'b0;
        avr_busy     = 1'b0;
        bus.data     = 8'h00;
        bus.new_data = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset tx", tx, 1'b1);
        check_eq("reset busy", bus.busy, 1'b0);
        check_eq("reset full ready0", bus.full, 1'b1);
        ready = 1'b1;
        #1 check_eq("reset full ready1", bus.full, 1'b0);
        ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Writes refused while the AVR is not ready
        bus.data     = 8'h55;
        bus.new_data = 1'b1;
        #1 check_eq("notready full", bus.full, 1'b1);
        @(negedge clk);
        bus.new_data = 1'b0;
        check_eq("notready busy", bus.busy, 1'b0);
        idle_check("notready", 4);
        check_eq("notready busy after", bus.busy, 1'b0);

        // Single byte, first-frame latency and exact frame shape
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("ready full", bus.full, 1'b0);
        write_byte(8'hA5);
        check_eq("A5 latency tx", tx, 1'b1);
        check_eq("A5 queued busy", bus.busy, 1'b1);
        @(negedge clk);
        frame_check(8'hA5, -1);
        check_eq("A5 end busy", bus.busy, 1'b0);
        idle_check("A5 after", 3);

        // Fill the FIFO while the AVR holds off, then drain back-to-back
        avr_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            bus.data     = 8'(k);
            bus.new_data = 1'b1;
            #1 check_eq($sformatf("fill full %0d", k), bus.full, 1'b0);
            @(negedge clk);
        end
        bus.data = 8'h05;
        #1 check_eq("fifo full", bus.full, 1'b1);
        @(negedge clk);
        bus.new_data = 1'b0;
        check_eq("held busy", bus.busy, 1'b1);
        idle_check("held", 5);
        avr_busy = 1'b0;
        @(negedge clk);
        check_eq("release sync1 tx", tx, 1'b1);
        @(negedge clk);
        check_eq("release sync2 tx", tx, 1'b1);
        @(negedge clk);
        frame_check(8'h01, -1);
        frame_check(8'h02, -1);
        frame_check(8'h03, -1);
        frame_check(8'h04, -1);
        check_eq("drain busy", bus.busy, 1'b0);
        idle_check("drain after", 45);
        check_eq("no 05 busy", bus.busy, 1'b0);

        // avr_busy raised mid-frame holds off the queued byte
        bus.data     = 8'h01;
        bus.new_data = 1'b1;
        @(negedge clk);
        bus.data = 8'h02;
        @(negedge clk);
        bus.new_data = 1'b0;
        frame_check(8'h01, 10);
        check_eq("pause busy", bus.busy, 1'b1);
        idle_check("pause", 4);
        avr_busy = 1'b0;
        @(negedge clk);
        check_eq("resume sync1 tx", tx, 1'b1);
        @(negedge clk);
        check_eq("resume sync2 tx", tx, 1'b1);
        @(negedge clk);
        frame_check(8'h02, -1);
        check_eq("resume end busy", bus.busy, 1'b0);

        // ready drops during DATA: abort, flush, nothing stale afterwards
        bus.data     = 8'h00;
        bus.new_data = 1'b1;
        @(negedge clk);
        bus.data = 8'h3C;
        @(negedge clk);
        bus.new_data = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check_eq($sformatf("abort pre cyc %0d", i), tx, 1'b0);
            @(negedge clk);
        end
        ready = 1'b0;
        @(negedge clk);
        check_eq("abort tx", tx, 1'b1);
        check_eq("abort busy", bus.busy, 1'b0);
        check_eq("abort full", bus.full, 1'b1);
        repeat (3) @(negedge clk);
        ready = 1'b1;
        #1 check_eq("abort ready full", bus.full, 1'b0);
        @(negedge clk);
        idle_check("abort stale", 50);
        check_eq("abort stale busy", bus.busy, 1'b0);

        // Asynchronous reset in the middle of a frame
        write_byte(8'h00);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("arst pre cyc %0d", i), tx, 1'b0);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 check_eq("arst tx", tx, 1'b1);
        check_eq("arst busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("arst full", bus.full, 1'b0);
        idle_check("arst after", 10);
        check_eq("arst after busy", bus.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
